// File: rtl/pulpemu_axi_mailbox.sv
// AXI4 slave mailbox: PULP pushes words into a FIFO through a DATA register and
// polls STATUS/CMD; the PS side drains the FIFO through a valid/ready port.
module pulpemu_axi_mailbox #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned IRQ_THRESHOLD  = 1
) (
  input  logic                        zynq_clk,
  input  logic                        zynq_rst_n,
  input  logic                        axi_aw_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [7:0]                  axi_aw_len_i,
  input  logic [2:0]                  axi_aw_size_i,
  input  logic [1:0]                  axi_aw_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [2:0]                  axi_aw_prot_i,
  input  logic [3:0]                  axi_aw_region_i,
  input  logic                        axi_aw_lock_i,
  input  logic [3:0]                  axi_aw_cache_i,
  input  logic [3:0]                  axi_aw_qos_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_aw_user_i,
  output logic                        axi_aw_ready_o,
  input  logic                        axi_w_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                        axi_w_last_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_w_user_i,
  output logic                        axi_w_ready_o,
  output logic                        axi_b_valid_o,
  output logic [1:0]                  axi_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_b_user_o,
  input  logic                        axi_b_ready_i,
  input  logic                        axi_ar_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [7:0]                  axi_ar_len_i,
  input  logic [2:0]                  axi_ar_size_i,
  input  logic [1:0]                  axi_ar_burst_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [2:0]                  axi_ar_prot_i,
  input  logic [3:0]                  axi_ar_region_i,
  input  logic                        axi_ar_lock_i,
  input  logic [3:0]                  axi_ar_cache_i,
  input  logic [3:0]                  axi_ar_qos_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_ar_user_i,
  output logic                        axi_ar_ready_o,
  output logic                        axi_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
  output logic [1:0]                  axi_r_resp_o,
  output logic                        axi_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_r_user_o,
  input  logic                        axi_r_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   ps_data_o,
  output logic                        ps_valid_o,
  input  logic                        ps_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   ps_cmd_i,
  output logic                        irq_o
);

  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CMD     = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e                w_state_q, w_state_d;
  logic                    aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic [AXI_ID_WIDTH-1:0] b_id_q, b_id_d;
  logic [1:0]              w_addr_q, w_addr_d;
  logic [7:0]              w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                    w_fixed_q, w_fixed_d, w_size_err_q, w_size_err_d;
  logic                    w_err_q, w_err_d;

  r_state_e                r_state_q, r_state_d;
  logic                    ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [DW-1:0]           r_data_q, r_data_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic                    r_last_q, r_last_d;
  logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [1:0]              r_addr_q, r_addr_d, r_addr_next;
  logic [7:0]              r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                    r_fixed_q, r_fixed_d, r_size_err_q, r_size_err_d;

  logic [DW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DW-1:0]           head_q, head_d;
  logic                    ps_valid_q, ps_valid_d, irq_q, irq_d;

  logic                    push, pop, ovf_set, ovf_clr, w_last_beat;
  logic [DW-1:0]           status_word;

  function automatic logic [DW-1:0] read_word(input logic [1:0] sel,
                                              input logic [DW-1:0] status,
                                              input logic [DW-1:0] cmd);
    logic [DW-1:0] word;
    word = '0;
    if (sel == REG_STATUS) word = status;
    else if (sel == REG_CMD) word = cmd;
    return word;
  endfunction

  assign status_word = DW'({16'h0, 8'(count_q), 5'h0, overflow_q,
                            count_q == FULL_LVL, count_q == '0});

  // Write channel FSM; beat side effects are flagged here and applied in the FIFO block
  always_comb begin
    w_state_d    = w_state_q;
    aw_ready_d   = aw_ready_q;
    w_ready_d    = w_ready_q;
    b_valid_d    = b_valid_q;
    b_resp_d     = b_resp_q;
    b_id_d       = b_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_beat_d     = w_beat_q;
    w_fixed_d    = w_fixed_q;
    w_size_err_d = w_size_err_q;
    w_err_d      = w_err_q;
    push         = 1'b0;
    ovf_set      = 1'b0;
    ovf_clr      = 1'b0;
    w_last_beat  = (w_beat_q == w_len_q);
    unique case (w_state_q)
      W_IDLE: begin
        if (axi_aw_valid_i) begin
          w_state_d    = W_DATA;
          aw_ready_d   = 1'b0;
          w_ready_d    = 1'b1;
          w_addr_d     = axi_aw_addr_i[3:2];
          w_len_d      = axi_aw_len_i;
          w_fixed_d    = (axi_aw_burst_i == BURST_FIXED);
          w_size_err_d = (axi_aw_size_i != 3'd2);
          w_err_d      = (axi_aw_size_i != 3'd2);
          w_beat_d     = '0;
          b_id_d       = axi_aw_id_i;
        end
      end
      W_DATA: begin
        if (axi_w_valid_i) begin
          if (!w_size_err_q) begin
            if (w_addr_q == REG_DATA && |axi_w_strb_i) begin
              if (count_q < FULL_LVL) begin
                push = 1'b1;
              end else begin
                ovf_set = 1'b1;
                w_err_d = 1'b1;
              end
            end
            if (w_addr_q == REG_STATUS && axi_w_data_i[2]) ovf_clr = 1'b1;
          end
          if (axi_w_last_i != w_last_beat) w_err_d = 1'b1;
          if (!w_fixed_q) w_addr_d = w_addr_q + 2'd1;
          w_beat_d = w_beat_q + 8'd1;
          if (w_last_beat) begin
            w_state_d = W_RESP;
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) begin
          w_state_d  = W_IDLE;
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign r_addr_next = r_fixed_q ? r_addr_q : r_addr_q + 2'd1;

  // Read channel FSM; beat data is captured when the beat is loaded and held while stalled
  always_comb begin
    r_state_d    = r_state_q;
    ar_ready_d   = ar_ready_q;
    r_valid_d    = r_valid_q;
    r_data_d     = r_data_q;
    r_resp_d     = r_resp_q;
    r_last_d     = r_last_q;
    r_id_d       = r_id_q;
    r_addr_d     = r_addr_q;
    r_len_d      = r_len_q;
    r_beat_d     = r_beat_q;
    r_fixed_d    = r_fixed_q;
    r_size_err_d = r_size_err_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (axi_ar_valid_i) begin
          r_state_d    = R_DATA;
          ar_ready_d   = 1'b0;
          r_valid_d    = 1'b1;
          r_addr_d     = axi_ar_addr_i[3:2];
          r_len_d      = axi_ar_len_i;
          r_fixed_d    = (axi_ar_burst_i == BURST_FIXED);
          r_size_err_d = (axi_ar_size_i != 3'd2);
          r_beat_d     = '0;
          r_id_d       = axi_ar_id_i;
          r_last_d     = (axi_ar_len_i == 8'd0);
          r_resp_d     = r_size_err_d ? RESP_SLVERR : RESP_OKAY;
          r_data_d     = r_size_err_d ? '0 :
                         read_word(axi_ar_addr_i[3:2], status_word, ps_cmd_i);
        end
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          if (r_last_q) begin
            r_state_d  = R_IDLE;
            r_valid_d  = 1'b0;
            r_last_d   = 1'b0;
            ar_ready_d = 1'b1;
          end else begin
            r_addr_d = r_addr_next;
            r_beat_d = r_beat_q + 8'd1;
            r_last_d = (r_beat_d == r_len_q);
            r_data_d = r_size_err_q ? '0 : read_word(r_addr_next, status_word, ps_cmd_i);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FIFO bookkeeping; the head word is kept in its own register for show-ahead output
  always_comb begin
    pop        = (count_q != '0) && ps_ready_i;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    head_d     = head_q;
    if (count_q == '0) begin
      if (push) head_d = axi_w_data_i;
    end else if (pop) begin
      if (count_q == CW'(1)) head_d = push ? axi_w_data_i : '0;
      else head_d = mem_q[rd_ptr_q + PW'(1)];
    end
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
    ps_valid_d = (count_d != '0);
    irq_d      = (count_d >= CW'(IRQ_THRESHOLD)) || overflow_d;
  end

  always_ff @(posedge zynq_clk) begin
    if (push) mem_q[wr_ptr_q] <= axi_w_data_i;
  end

  always_ff @(posedge zynq_clk or negedge zynq_rst_n) begin
    if (!zynq_rst_n) begin
      w_state_q    <= W_IDLE;
      aw_ready_q   <= 1'b1;
      w_ready_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      b_resp_q     <= '0;
      b_id_q       <= '0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_beat_q     <= '0;
      w_fixed_q    <= 1'b0;
      w_size_err_q <= 1'b0;
      w_err_q      <= 1'b0;
      r_state_q    <= R_IDLE;
      ar_ready_q   <= 1'b1;
      r_valid_q    <= 1'b0;
      r_data_q     <= '0;
      r_resp_q     <= '0;
      r_last_q     <= 1'b0;
      r_id_q       <= '0;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_beat_q     <= '0;
      r_fixed_q    <= 1'b0;
      r_size_err_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      head_q       <= '0;
      ps_valid_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      aw_ready_q   <= aw_ready_d;
      w_ready_q    <= w_ready_d;
      b_valid_q    <= b_valid_d;
      b_resp_q     <= b_resp_d;
      b_id_q       <= b_id_d;
      w_addr_q     <= w_addr_d;
      w_len_q      <= w_len_d;
      w_beat_q     <= w_beat_d;
      w_fixed_q    <= w_fixed_d;
      w_size_err_q <= w_size_err_d;
      w_err_q      <= w_err_d;
      r_state_q    <= r_state_d;
      ar_ready_q   <= ar_ready_d;
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      r_resp_q     <= r_resp_d;
      r_last_q     <= r_last_d;
      r_id_q       <= r_id_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      r_beat_q     <= r_beat_d;
      r_fixed_q    <= r_fixed_d;
      r_size_err_q <= r_size_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      head_q       <= head_d;
      ps_valid_q   <= ps_valid_d;
      irq_q        <= irq_d;
    end
  end

  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_b_id_o     = b_id_q;
  assign axi_b_user_o   = '0;
  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_last_o   = r_last_q;
  assign axi_r_id_o     = r_id_q;
  assign axi_r_user_o   = '0;
  assign ps_data_o      = head_q;
  assign ps_valid_o     = ps_valid_q;
  assign irq_o          = irq_q;

  // Sideband fields and undecoded address bits have no effect on this slave
  logic unused_inputs;
  assign unused_inputs = ^{axi_aw_addr_i[AXI_ADDR_WIDTH-1:4], axi_aw_addr_i[1:0],
                           axi_aw_prot_i, axi_aw_region_i, axi_aw_lock_i, axi_aw_cache_i,
                           axi_aw_qos_i, axi_aw_user_i, axi_w_user_i,
                           axi_ar_addr_i[AXI_ADDR_WIDTH-1:4], axi_ar_addr_i[1:0],
                           axi_ar_prot_i, axi_ar_region_i, axi_ar_lock_i, axi_ar_cache_i,
                           axi_ar_qos_i, axi_ar_user_i};

endmodule

// File: tb/tb_pulpemu_axi_mailbox.sv
// Scoreboard bench for pulpemu_axi_mailbox: directed AXI traffic, expected B/R/PS
// responses queued at issue time and checked by independent monitors.
module tb_pulpemu_axi_mailbox;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        aw_valid, aw_lock, aw_ready, w_valid, w_last, w_ready;
  logic [31:0] aw_addr, ar_addr, w_data, r_data, ps_data, ps_cmd;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [15:0] aw_id, ar_id, b_id, r_id;
  logic [3:0]  aw_region, aw_cache, aw_qos, ar_region, ar_cache, ar_qos, w_strb;
  logic [0:0]  aw_user, w_user, ar_user, b_user, r_user;
  logic        b_valid, b_ready, ar_valid, ar_lock, ar_ready;
  logic        r_valid, r_last, r_ready, ps_valid, ps_ready, irq;

  pulpemu_axi_mailbox dut (
    .zynq_clk(clk), .zynq_rst_n(rst_n),
    .axi_aw_valid_i(aw_valid), .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len),
    .axi_aw_size_i(aw_size), .axi_aw_burst_i(aw_burst), .axi_aw_id_i(aw_id),
    .axi_aw_prot_i(aw_prot), .axi_aw_region_i(aw_region), .axi_aw_lock_i(aw_lock),
    .axi_aw_cache_i(aw_cache), .axi_aw_qos_i(aw_qos), .axi_aw_user_i(aw_user),
    .axi_aw_ready_o(aw_ready),
    .axi_w_valid_i(w_valid), .axi_w_data_i(w_data), .axi_w_strb_i(w_strb),
    .axi_w_last_i(w_last), .axi_w_user_i(w_user), .axi_w_ready_o(w_ready),
    .axi_b_valid_o(b_valid), .axi_b_resp_o(b_resp), .axi_b_id_o(b_id),
    .axi_b_user_o(b_user), .axi_b_ready_i(b_ready),
    .axi_ar_valid_i(ar_valid), .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len),
    .axi_ar_size_i(ar_size), .axi_ar_burst_i(ar_burst), .axi_ar_id_i(ar_id),
    .axi_ar_prot_i(ar_prot), .axi_ar_region_i(ar_region), .axi_ar_lock_i(ar_lock),
    .axi_ar_cache_i(ar_cache), .axi_ar_qos_i(ar_qos), .axi_ar_user_i(ar_user),
    .axi_ar_ready_o(ar_ready),
    .axi_r_valid_o(r_valid), .axi_r_data_o(r_data), .axi_r_resp_o(r_resp),
    .axi_r_last_o(r_last), .axi_r_id_o(r_id), .axi_r_user_o(r_user),
    .axi_r_ready_i(r_ready),
    .ps_data_o(ps_data), .ps_valid_o(ps_valid), .ps_ready_i(ps_ready),
    .ps_cmd_i(ps_cmd), .irq_o(irq)
  );

  typedef struct packed { logic [1:0] resp; logic [15:0] id; } b_exp_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; logic [15:0] id; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] pq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output presented with nothing expected (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin : mon_b
    b_exp_t e;
    if (b_valid) begin
      if (bq.size() == 0) unexpected("b_unexpected");
      else if (b_ready) begin
        e = bq.pop_front();
        check("b_resp", 32'(b_resp), 32'(e.resp));
        check("b_id", 32'(b_id), 32'(e.id));
      end
    end
  end

  always @(negedge clk) begin : mon_r
    r_exp_t e;
    if (r_valid) begin
      if (rq.size() == 0) unexpected("r_unexpected");
      else begin
        e = rq[0];
        check("r_data", r_data, e.data);
        check("r_resp", 32'(r_resp), 32'(e.resp));
        check("r_last", 32'(r_last), 32'(e.last));
        check("r_id", 32'(r_id), 32'(e.id));
        if (r_ready) rq.delete(0);
      end
    end
  end

  always @(negedge clk) begin : mon_ps
    logic [31:0] e;
    if (ps_valid && ps_ready) begin
      if (pq.size() == 0) unexpected("ps_unexpected");
      else begin
        e = pq.pop_front();
        check("ps_data", ps_data, e);
      end
    end
  end

  task automatic expect_r(input logic [31:0] data, input logic [1:0] resp,
                          input logic last, input logic [15:0] id);
    r_exp_t e;
    e.data = data; e.resp = resp; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [15:0] id, input logic [31:0] base,
                           input bit early_last, input bit pop_on_beat, input logic [1:0] exp_resp);
    b_exp_t e;
    int n;
    e.resp = exp_resp; e.id = id;
    bq.push_back(e);
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
    n = 0;
    @(negedge clk);
    while (!aw_ready && n < 50) begin @(negedge clk); n++; end
    check("aw_ready", 32'(aw_ready), 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1;
      w_data  = base + 32'(i);
      w_strb  = 4'hF;
      w_last  = early_last ? (i == 0) : (i == int'(len));
      if (pop_on_beat) ps_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!w_ready && n < 50) begin @(negedge clk); n++; end
      check("w_ready", 32'(w_ready), 32'd1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    if (pop_on_beat) ps_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [15:0] id, input bit toggle);
    int  n;
    bit  done;
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = 3'd2; ar_burst = burst; ar_id = id;
    n = 0;
    @(negedge clk);
    while (!ar_ready && n < 50) begin @(negedge clk); n++; end
    check("ar_ready", 32'(ar_ready), 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    r_ready  = toggle ? 1'b0 : 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (r_valid && r_ready && r_last) done = 1'b1;
      @(posedge clk); #1;
      n++;
      if (toggle) r_ready = ~r_ready;
    end
    r_ready = 1'b0;
    check("r_complete", 32'(done), 32'd1);
  endtask

  task automatic pop_words(input int n);
    @(posedge clk); #1;
    ps_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    ps_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin @(negedge clk); n++; end
    check("responses_drained", 32'(bq.size() + rq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_id = 0;
    aw_prot = 0; aw_region = 0; aw_lock = 0; aw_cache = 0; aw_qos = 0; aw_user = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; w_user = 0; b_ready = 1'b1;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_id = 0;
    ar_prot = 0; ar_region = 0; ar_lock = 0; ar_cache = 0; ar_qos = 0; ar_user = 0;
    r_ready = 0; ps_ready = 0; ps_cmd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_ready", 32'(aw_ready), 32'd1);
    check("rst_ar_ready", 32'(ar_ready), 32'd1);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_ps_valid", 32'(ps_valid), 32'd0);
    check("rst_ps_data", ps_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_r_data", r_data, 32'd0);
    check("rst_users", 32'({b_user, r_user}), 32'd0);
    rst_n = 1'b1;

    // Single write to DATA
    axi_write(32'h0, 8'd0, 3'd2, INCR, 16'h0011, 32'hDEADBEEF, 1'b0, 1'b0, OKAY);
    check("t1_ps_valid", 32'(ps_valid), 32'd1);
    check("t1_ps_data", ps_data, 32'hDEADBEEF);
    check("t1_irq", 32'(irq), 32'd1);
    wait_idle();
    pq.push_back(32'hDEADBEEF);
    pop_words(1);
    check("t1_empty", 32'(ps_valid), 32'd0);
    check("t1_irq_clear", 32'(irq), 32'd0);

    // FIXED burst of 18 beats into a 16-deep FIFO
    axi_write(32'h0, 8'd17, 3'd2, FIXED, 16'h0022, 32'hA0000000, 1'b0, 1'b0, SLVERR);
    expect_r(32'h0000_1006, OKAY, 1'b1, 16'h0023);
    axi_read(32'h4, 8'd0, INCR, 16'h0023, 1'b0);
    check("t2_head", ps_data, 32'hA0000000);
    check("t2_irq", 32'(irq), 32'd1);
    wait_idle();

    // Clear overflow, drain, observe empty status
    axi_write(32'h4, 8'd0, 3'd2, INCR, 16'h0031, 32'h4, 1'b0, 1'b0, OKAY);
    expect_r(32'h0000_1002, OKAY, 1'b1, 16'h0032);
    axi_read(32'h4, 8'd0, INCR, 16'h0032, 1'b0);
    for (int i = 0; i < 16; i++) pq.push_back(32'hA0000000 + 32'(i));
    pop_words(16);
    check("t3_irq_after_drain", 32'(irq), 32'd0);
    check("t3_ps_valid", 32'(ps_valid), 32'd0);
    expect_r(32'h0000_0001, OKAY, 1'b1, 16'h0033);
    axi_read(32'h4, 8'd0, INCR, 16'h0033, 1'b0);
    wait_idle();

    // INCR read that wraps the 4-entry map, with r_ready stalls
    ps_cmd = 32'h1234_5678;
    expect_r(32'h0, OKAY, 1'b0, 16'h0042);
    expect_r(32'h0000_0001, OKAY, 1'b0, 16'h0042);
    expect_r(32'h1234_5678, OKAY, 1'b0, 16'h0042);
    expect_r(32'h0, OKAY, 1'b0, 16'h0042);
    expect_r(32'h0, OKAY, 1'b1, 16'h0042);
    axi_read(32'h0, 8'd4, INCR, 16'h0042, 1'b1);
    wait_idle();

    // Push and pop in the same cycle while full: push refused, pop still happens
    axi_write(32'h0, 8'd15, 3'd2, FIXED, 16'h0051, 32'hB0000000, 1'b0, 1'b0, OKAY);
    expect_r(32'h0000_1002, OKAY, 1'b1, 16'h0055);
    axi_read(32'h4, 8'd0, INCR, 16'h0055, 1'b0);
    pq.push_back(32'hB0000000);
    axi_write(32'h0, 8'd0, 3'd2, INCR, 16'h0052, 32'hC0000000, 1'b0, 1'b1, SLVERR);
    expect_r(32'h0000_0F04, OKAY, 1'b1, 16'h0056);
    axi_read(32'h4, 8'd0, INCR, 16'h0056, 1'b0);
    check("t5_irq_ovf", 32'(irq), 32'd1);
    axi_write(32'h4, 8'd0, 3'd2, INCR, 16'h0057, 32'h4, 1'b0, 1'b0, OKAY);
    for (int i = 1; i < 16; i++) pq.push_back(32'hB0000000 + 32'(i));
    pop_words(15);
    check("t5_drained", 32'(ps_valid), 32'd0);
    wait_idle();

    // Wrong beat size and early w_last
    axi_write(32'h0, 8'd0, 3'd1, INCR, 16'h0053, 32'hC0DE0000, 1'b0, 1'b0, SLVERR);
    wait_idle();
    check("t5_size_no_push", 32'(ps_valid), 32'd0);
    axi_write(32'h8, 8'd1, 3'd2, INCR, 16'h0054, 32'h0, 1'b1, 1'b0, SLVERR);
    wait_idle();
    check("t5_early_last_no_push", 32'(ps_valid), 32'd0);
    check("t5_irq_idle", 32'(irq), 32'd0);

    // Reset in the middle of a FIXED write burst
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_addr = 32'h0; aw_len = 8'd7; aw_size = 3'd2; aw_burst = FIXED; aw_id = 16'h0066;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!aw_ready && n < 50) begin @(negedge clk); n++; end
      check("t6_aw_ready", 32'(aw_ready), 32'd1);
    end
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_valid = 1'b1; w_data = 32'hE0000000; w_strb = 4'hF; w_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_mid_burst_valid", 32'(ps_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_ps_valid", 32'(ps_valid), 32'd0);
    check("t6_async_aw_ready", 32'(aw_ready), 32'd1);
    w_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t6_no_b_valid", 32'(b_valid), 32'd0);
    end
    check("t6_aw_ready_after", 32'(aw_ready), 32'd1);
    check("t6_ps_valid_after", 32'(ps_valid), 32'd0);
    check("t6_w_ready_after", 32'(w_ready), 32'd0);

    wait_idle();
    check("ps_queue_drained", 32'(pq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
